// File: rtl/scoreboard_hazard_unit_pkg.sv
//----------------------------------------------------------------------------
// scoreboard_hazard_unit_pkg: shared opcode, register, pipe-mask and src/dst
// encodings for the hazard unit. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef OP_CODE_BITS
`define OP_CODE_BITS 6
`endif
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif

package scoreboard_hazard_unit_pkg;

  localparam int OP_CODE_BITS   = `OP_CODE_BITS;
  localparam int REG_BITS       = `NUM_REGISTERS_LOG2;
  localparam int NUM_PIPE_MASKS = `NUM_PIPE_MASKS;

  localparam int PIPE_REG_PC     = 0;
  localparam int PIPE_REG_IF_ID  = 1;
  localparam int PIPE_REG_ID_EX  = 2;
  localparam int PIPE_REG_EX_MEM = 3;
  localparam int PIPE_REG_MEM_WB = 4;

  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_MASK_PC    = NUM_PIPE_MASKS'(1) << PIPE_REG_PC;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_MASK_IF_ID = NUM_PIPE_MASKS'(1) << PIPE_REG_IF_ID;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_MASK_ID_EX = NUM_PIPE_MASKS'(1) << PIPE_REG_ID_EX;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [OP_CODE_BITS-1:0] OP_CODE_NOP = 6'b000000;
  localparam logic [OP_CODE_BITS-1:0] OP_CODE_JR  = 6'b001000;
  localparam logic [OP_CODE_BITS-1:0] OP_CODE_LW  = 6'b100011;
  localparam logic [OP_CODE_BITS-1:0] OP_CODE_SW  = 6'b101011;
  localparam logic [OP_CODE_BITS-1:0] OP_CODE_LA  = 6'b100000;
  localparam logic [OP_CODE_BITS-1:0] OP_CODE_SA  = 6'b101000;

  // Source mask: bit2 = rs, bit1 = rt. Destination mask: bit1 = rt, bit0 = rd.
  localparam logic [2:0] SRC_RS = 3'b100;
  localparam logic [2:0] SRC_RT = 3'b010;
  localparam logic [2:0] DST_RT = 3'b010;
  localparam logic [2:0] DST_RD = 3'b001;

endpackage

`default_nettype wire

// File: rtl/scoreboard_hazard_unit_slot_decode.sv
//----------------------------------------------------------------------------
// hazard_slot_decode: maps one slot's opcode to its source/destination masks.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module hazard_slot_decode
  import scoreboard_hazard_unit_pkg::*;
(
  input  logic [OP_CODE_BITS-1:0] opcode,
  output logic [2:0]              src_mask,
  output logic [2:0]              dst_mask
);

  always_comb begin
    src_mask = 3'b000;
    dst_mask = 3'b000;
    // NOP and JR live inside the 00xxxx space, so they are matched first.
    if (opcode == OP_CODE_NOP) begin
      src_mask = 3'b000;
    end else if (opcode == OP_CODE_JR) begin
      src_mask = SRC_RS;
    end else if (opcode[OP_CODE_BITS-1 -: 2] == 2'b00) begin
      src_mask = SRC_RS | SRC_RT;
      dst_mask = DST_RD;
    end else if (opcode[OP_CODE_BITS-1 -: 2] == 2'b01) begin
      src_mask = SRC_RS;
      dst_mask = DST_RT;
    end else if (opcode == OP_CODE_LW) begin
      src_mask = SRC_RS;
      dst_mask = DST_RT;
    end else if (opcode == OP_CODE_SW) begin
      src_mask = SRC_RS | SRC_RT;
    end else if (opcode == OP_CODE_LA) begin
      dst_mask = DST_RT;
    end else if (opcode == OP_CODE_SA) begin
      src_mask = SRC_RT;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scoreboard_hazard_unit.sv
//----------------------------------------------------------------------------
// scoreboard_hazard_unit: N-wide load-use scoreboard and intra-bundle split
// detector. Option HAZARD_PERF_CNT_EN adds hazard perf counters. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int ISSUE_WIDTH  = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int NUM_REGS     = 2**REG_BITS,
  localparam int OLDEST_W    = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ISSUE_WIDTH*OP_CODE_BITS-1:0] if_id_opcode,
  input  logic [ISSUE_WIDTH*REG_BITS-1:0]     if_id_rs,
  input  logic [ISSUE_WIDTH*REG_BITS-1:0]     if_id_rt,
  input  logic [ISSUE_WIDTH*REG_BITS-1:0]     if_id_rd,
  input  logic [OLDEST_W-1:0]                 oldest,
  input  logic                                flush,
  output logic [ISSUE_WIDTH*NUM_PIPE_MASKS-1:0] stall,
  output logic [ISSUE_WIDTH*NUM_PIPE_MASKS-1:0] nop
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                         load_use_cycles,
  output logic [31:0]                         split_cycles
`endif
);

  localparam int NPM   = NUM_PIPE_MASKS;
  localparam int CNT_W = $clog2(LOAD_LATENCY + 1);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LATENCY);
  localparam logic [NPM-1:0] STALL_HELD   = PIPE_MASK_PC | PIPE_MASK_IF_ID | PIPE_MASK_ID_EX;
  localparam logic [NPM-1:0] STALL_ISSUED = PIPE_MASK_PC | PIPE_MASK_IF_ID;

  logic [OP_CODE_BITS-1:0] opc      [ISSUE_WIDTH];
  logic [REG_BITS-1:0]     rs       [ISSUE_WIDTH];
  logic [REG_BITS-1:0]     rt       [ISSUE_WIDTH];
  logic [REG_BITS-1:0]     rd       [ISSUE_WIDTH];
  logic [2:0]              src_mask [ISSUE_WIDTH];
  logic [2:0]              dst_mask [ISSUE_WIDTH];

  logic [CNT_W-1:0]        busy_cnt [NUM_REGS];
  logic [NUM_REGS-1:0]     busy;
  logic [NUM_REGS-1:0]     set_busy;
  logic                    load_use;
  logic                    split;
  int                      split_pos;
  logic [ISSUE_WIDTH-1:0]  held;

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
    assign opc[i] = if_id_opcode[i*OP_CODE_BITS +: OP_CODE_BITS];
    assign rs[i]  = if_id_rs[i*REG_BITS +: REG_BITS];
    assign rt[i]  = if_id_rt[i*REG_BITS +: REG_BITS];
    assign rd[i]  = if_id_rd[i*REG_BITS +: REG_BITS];

    hazard_slot_decode u_decode (
      .opcode   (opc[i]),
      .src_mask (src_mask[i]),
      .dst_mask (dst_mask[i])
    );
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
    assign busy[r] = (busy_cnt[r] != '0);
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if ((src_mask[i][2] && busy[rs[i]]) || (src_mask[i][1] && busy[rt[i]]))
        load_use = 1'b1;
    end
  end

  // Walk the bundle oldest-first, accumulating destinations written so far.
  always_comb begin : split_search
    logic [NUM_REGS-1:0] written;
    int                  s;
    written   = '0;
    split     = 1'b0;
    split_pos = 0;
    s         = 0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      s = (int'(oldest) + p) % ISSUE_WIDTH;
      if (!split && ((src_mask[s][2] && written[rs[s]]) ||
                     (src_mask[s][1] && written[rt[s]]))) begin
        split     = 1'b1;
        split_pos = p;
      end
      if (dst_mask[s][1]) written[rt[s]] = 1'b1;
      if (dst_mask[s][0]) written[rd[s]] = 1'b1;
    end
  end

  always_comb begin : mask_drive
    int pos;
    stall = '0;
    nop   = '0;
    held  = '0;
    pos   = 0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      pos = (i + ISSUE_WIDTH - int'(oldest) % ISSUE_WIDTH) % ISSUE_WIDTH;
      held[i] = load_use || (split && (pos >= split_pos));
      if (!reset) begin
        if (held[i]) begin
          stall[i*NPM +: NPM] = STALL_HELD;
          nop[i*NPM +: NPM]   = PIPE_MASK_ID_EX;
        end else if (split) begin
          stall[i*NPM +: NPM] = STALL_ISSUED;
          nop[i*NPM +: NPM]   = PIPE_MASK_IF_ID;
        end
      end
    end
  end

  always_comb begin
    set_busy = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (!held[i] && !flush && (opc[i] == OP_CODE_LW))
        set_busy[rt[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) busy_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (set_busy[r])
          busy_cnt[r] <= LOAD_CNT;
        else if (busy[r])
          busy_cnt[r] <= busy_cnt[r] - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_use_cycles <= 32'd0;
      split_cycles    <= 32'd0;
    end else if (load_use) begin
      if (load_use_cycles != 32'hFFFF_FFFF) load_use_cycles <= load_use_cycles + 32'd1;
    end else if (split) begin
      if (split_cycles != 32'hFFFF_FFFF) split_cycles <= split_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_hazard_unit.sv
//----------------------------------------------------------------------------
// tb_scoreboard_hazard_unit: vector table, corner sequences and a random run
// checked against a ready-time reference model. Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_scoreboard_hazard_unit;
  import scoreboard_hazard_unit_pkg::*;

  localparam int W   = 4;
  localparam int LL  = 2;
  localparam int NR  = 2**REG_BITS;
  localparam int NPM = NUM_PIPE_MASKS;
  localparam logic [5:0] OP_ADD  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b010000;
  localparam logic [5:0] OP_11   = 6'b110000;
  localparam logic [5:0] OP_10X  = 6'b100101;
  localparam logic [NPM-1:0] S_PART = 5'b00011;
  localparam logic [NPM-1:0] N_PART = 5'b00010;
  localparam logic [NPM-1:0] S_FULL = 5'b00111;
  localparam logic [NPM-1:0] N_FULL = 5'b00100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [1:0] oldest = '0;
  logic [W-1:0][OP_CODE_BITS-1:0] op;
  logic [W-1:0][REG_BITS-1:0] rs, rt, rd;
  logic [W*NPM-1:0] stall, nop;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cycles, sp_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ready_at [NR];
  int m_lu = 0;
  int m_sp = 0;

  scoreboard_hazard_unit #(.ISSUE_WIDTH(W), .LOAD_LATENCY(LL)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_id_opcode (op),
    .if_id_rs     (rs),
    .if_id_rt     (rt),
    .if_id_rd     (rd),
    .oldest       (oldest),
    .flush        (flush),
    .stall        (stall),
    .nop          (nop)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .load_use_cycles (lu_cycles),
    .split_cycles    (sp_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    old;
    int    k;      // expected first dependent age position, -1 = none
    logic [W-1:0][OP_CODE_BITS-1:0] op;
    logic [W-1:0][REG_BITS-1:0] rs, rt, rd;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic vec_t blank(input string n, input int old);
    vec_t v;
    v.name = n;
    v.old  = old;
    v.k    = -1;
    for (int i = 0; i < W; i++) begin
      v.op[i] = OP_CODE_NOP;
      v.rs[i] = REG_BITS'(16 + i);
      v.rt[i] = REG_BITS'(20 + i);
      v.rd[i] = REG_BITS'(24 + i);
    end
    return v;
  endfunction

  task automatic set_idle();
    vec_t v;
    v = blank("idle", 0);
    op = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
    oldest = '0;
    flush  = 1'b0;
  endtask

  function automatic logic [W*NPM-1:0] exp_mask(input int old, input int k, input bit is_stall);
    logic [W-1:0][NPM-1:0] m;
    int pos;
    m = '0;
    for (int i = 0; i < W; i++) begin
      pos = (i - old + W) % W;
      if (k >= 0) begin
        if (pos < k) m[i] = is_stall ? S_PART : N_PART;
        else         m[i] = is_stall ? S_FULL : N_FULL;
      end
    end
    return m;
  endfunction

  function automatic void dec(input logic [5:0] o, output bit ers, output bit ert,
                              output bit drt, output bit drd);
    ers = 0; ert = 0; drt = 0; drd = 0;
    if (o == OP_CODE_NOP) ;
    else if (o == OP_CODE_JR) ers = 1;
    else if (o[5:4] == 2'b00) begin ers = 1; ert = 1; drd = 1; end
    else if (o[5:4] == 2'b01) begin ers = 1; drt = 1; end
    else if (o == OP_CODE_LW) begin ers = 1; drt = 1; end
    else if (o == OP_CODE_SW) begin ers = 1; ert = 1; end
    else if (o == OP_CODE_LA) drt = 1;
    else if (o == OP_CODE_SA) ert = 1;
  endfunction

  // Reference: a register is busy while the current cycle precedes its ready time.
  task automatic model(output logic [W*NPM-1:0] ms, output logic [W*NPM-1:0] mn,
                       output bit lu, output int k);
    bit wr [NR];
    bit ers, ert, drt, drd;
    int s;
    lu = 0; k = -1;
    foreach (wr[r]) wr[r] = 0;
    for (int p = 0; p < W; p++) begin
      s = (int'(oldest) + p) % W;
      dec(op[s], ers, ert, drt, drd);
      if (ers && cyc < ready_at[rs[s]]) lu = 1;
      if (ert && cyc < ready_at[rt[s]]) lu = 1;
      if (k < 0 && ((ers && wr[rs[s]]) || (ert && wr[rt[s]]))) k = p;
      if (drt) wr[rt[s]] = 1;
      if (drd) wr[rd[s]] = 1;
    end
    if (reset) begin
      ms = '0; mn = '0;
    end else if (lu) begin
      ms = {W{S_FULL}}; mn = {W{N_FULL}};
    end else begin
      ms = exp_mask(int'(oldest), k, 1'b1);
      mn = exp_mask(int'(oldest), k, 1'b0);
    end
  endtask

  task automatic check(input string tag, input bit has_exp,
                       input logic [W*NPM-1:0] es, input logic [W*NPM-1:0] en);
    logic [W*NPM-1:0] ms, mn;
    bit lu;
    int k;
    @(negedge clk);
    if (reset) begin
      foreach (ready_at[r]) ready_at[r] = 0;
      m_lu = 0; m_sp = 0;
    end
    model(ms, mn, lu, k);
    cmp({tag, " stall/model"}, 64'(stall), 64'(ms));
    cmp({tag, " nop/model"}, 64'(nop), 64'(mn));
    if (has_exp) begin
      cmp({tag, " stall"}, 64'(stall), 64'(es));
      cmp({tag, " nop"}, 64'(nop), 64'(en));
    end
`ifdef HAZARD_PERF_CNT_EN
    cmp({tag, " load_use_cycles"}, 64'(lu_cycles), 64'(m_lu));
    cmp({tag, " split_cycles"}, 64'(sp_cycles), 64'(m_sp));
`endif
    if (!reset) begin
      if (lu) m_lu++;
      else if (k >= 0) m_sp++;
      for (int s = 0; s < W; s++)
        if (!ms[s*NPM + 2] && !flush && op[s] == OP_CODE_LW)
          ready_at[rt[s]] = cyc + LL + 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pick_op(input int n);
    case (n)
      0: return OP_CODE_NOP;
      1: return OP_CODE_JR;
      2: return OP_ADD;
      3: return OP_ADDI;
      4: return OP_CODE_LW;
      5: return OP_CODE_SW;
      6: return OP_CODE_LA;
      7: return OP_CODE_SA;
      8: return OP_11;
      default: return OP_10X;
    endcase
  endfunction

  localparam logic [W*NPM-1:0] ALL_S = {W{S_FULL}};
  localparam logic [W*NPM-1:0] ALL_N = {W{N_FULL}};
  localparam logic [W*NPM-1:0] ZERO  = '0;

  initial begin
    vec_t v;
    foreach (ready_at[r]) ready_at[r] = 0;

    v = blank("all_nop", 0); tbl.push_back(v);
    v = blank("split_old2", 2); v.k = 2;
    v.op[2] = OP_ADDI; v.rt[2] = 3; v.op[0] = OP_ADD; v.rs[0] = 3; tbl.push_back(v);
    v = blank("no_dep_old0", 0);
    v.op[2] = OP_ADDI; v.rt[2] = 3; v.op[0] = OP_ADD; v.rs[0] = 3; tbl.push_back(v);
    v = blank("waw_ok", 0);
    v.op[0] = OP_ADDI; v.rt[0] = 5; v.op[1] = OP_ADDI; v.rt[1] = 5; v.rs[1] = 2; tbl.push_back(v);
    v = blank("rd_to_sw_rt", 0); v.k = 1;
    v.op[0] = OP_ADD; v.rd[0] = 8; v.op[1] = OP_CODE_SW; v.rt[1] = 8; tbl.push_back(v);
    v = blank("la_to_sa_wrap", 3); v.k = 1;
    v.op[3] = OP_CODE_LA; v.rt[3] = 10; v.op[0] = OP_CODE_SA; v.rt[0] = 10; tbl.push_back(v);
    v = blank("jr_rs", 1); v.k = 1;
    v.op[1] = OP_ADDI; v.rt[1] = 12; v.op[2] = OP_CODE_JR; v.rs[2] = 12; tbl.push_back(v);
    v = blank("op11_no_src", 0);
    v.op[0] = OP_ADDI; v.rt[0] = 4; v.op[1] = OP_11; v.rs[1] = 4; tbl.push_back(v);
    v = blank("first_dep", 0); v.k = 2;
    v.op[0] = OP_ADDI; v.rt[0] = 1; v.op[1] = OP_ADD; v.rs[1] = 7;
    v.op[2] = OP_ADD; v.rs[2] = 1; tbl.push_back(v);
    v = blank("lw_intra", 0); v.k = 1;
    v.op[0] = OP_CODE_LW; v.rt[0] = 9; v.op[1] = OP_ADD; v.rs[1] = 9; tbl.push_back(v);

    // Reset state: a hazardous bundle still yields zero masks.
    v = tbl[1];
    op = v.op; rs = v.rs; rt = v.rt; rd = v.rd; oldest = 2'(v.old);
    check("reset_forced", 1, ZERO, ZERO);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      op = tbl[i].op; rs = tbl[i].rs; rt = tbl[i].rt; rd = tbl[i].rd;
      oldest = 2'(tbl[i].old);
      flush  = 1'b1;
      check(tbl[i].name, 1, exp_mask(tbl[i].old, tbl[i].k, 1'b1),
            exp_mask(tbl[i].old, tbl[i].k, 1'b0));
    end

    // LW r5 then a reader: LL bubbles, then release.
    set_idle(); op[0] = OP_CODE_LW; rt[0] = 5;
    check("lw5_issue", 1, ZERO, ZERO);
    op[0] = OP_ADD; rt[0] = 20; rs[0] = 5;
    check("lw5_use_t1", 1, ALL_S, ALL_N);
    check("lw5_use_t2", 1, ALL_S, ALL_N);
    check("lw5_use_t3", 1, ZERO, ZERO);

    // Flushed LW records nothing.
    set_idle(); op[0] = OP_CODE_LW; rt[0] = 4; flush = 1'b1;
    check("lw4_flushed", 1, ZERO, ZERO);
    flush = 1'b0; op[0] = OP_ADD; rt[0] = 20; rs[0] = 4;
    check("lw4_use", 1, ZERO, ZERO);

    // Reset in the middle of a countdown drops the hazard.
    set_idle(); op[0] = OP_CODE_LW; rt[0] = 9;
    check("lw9_issue", 1, ZERO, ZERO);
    op[0] = OP_ADD; rt[0] = 20; rs[0] = 9; reset = 1'b1;
    check("lw9_reset", 1, ZERO, ZERO);
    reset = 1'b0;
    check("lw9_after_reset", 1, ZERO, ZERO);
`ifdef HAZARD_PERF_CNT_EN
    cmp("perf_lu_after_reset", 64'(lu_cycles), 64'd0);
    cmp("perf_sp_after_reset", 64'(sp_cycles), 64'd0);
`endif

    // Two LWs to r6 in one bundle.
    set_idle(); op[0] = OP_CODE_LW; rt[0] = 6; op[1] = OP_CODE_LW; rt[1] = 6;
    check("dual_lw6", 1, ZERO, ZERO);
    set_idle(); op[0] = OP_ADD; rs[0] = 6;
    check("lw6_use_t1", 1, ALL_S, ALL_N);
    check("lw6_use_t2", 1, ALL_S, ALL_N);
    check("lw6_use_t3", 1, ZERO, ZERO);

    // Load-use wins over a simultaneous split.
    set_idle(); op[0] = OP_CODE_LW; rt[0] = 7;
    check("lw7_issue", 1, ZERO, ZERO);
    set_idle(); op[0] = OP_ADDI; rt[0] = 11; op[1] = OP_ADD; rs[1] = 7; rt[1] = 11;
    check("lw7_prio", 1, ALL_S, ALL_N);
    set_idle();
    check("idle0", 1, ZERO, ZERO);
    check("idle1", 1, ZERO, ZERO);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < W; i++) begin
        op[i] = pick_op($urandom_range(0, 9));
        rs[i] = REG_BITS'($urandom_range(0, 7));
        rt[i] = REG_BITS'($urandom_range(0, 7));
        rd[i] = REG_BITS'($urandom_range(0, 7));
      end
      oldest = 2'($urandom_range(0, W - 1));
      flush  = ($urandom_range(0, 4) == 0);
      reset  = ($urandom_range(0, 29) == 0);
      check("random", 0, ZERO, ZERO);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
